radio_bank: RTL and testbench
=============================

// Module: radio_bank
// PURPOSE
//  Parametrised N-channel RC receiver PWM decoder; next generation of the per-channel radio inputs.
//  Measures each channel's high-pulse width in tmr_1Mhz ticks (1 us), offsets and saturates it to WIDTH bits.
//  Rejects out-of-range pulses, flags channels as lost after a timeout, and falls back to a default value.
//  Sits between the radio pins and the control/avionics logic; its flat value bus feeds the same consumers as before.
// PARAMETERS
//  CHANNELS    8       number of radio channels
//  WIDTH       10      output value width per channel
//  OFFSET      988     us subtracted from measured pulse (988..2011 us -> 0..1023)
//  MIN_PULSE   800     shortest accepted pulse, us (inclusive)
//  MAX_PULSE   2200    longest accepted pulse, us (inclusive)
//  TIMEOUT     25000   us without a valid pulse before the channel is declared lost
//  DEFAULT     0       WIDTH-bit value driven while a channel is lost or in reset
// PORTS
//  tmr_1Mhz     in   1                 1 MHz clock; all logic on rising edge
//  rst          in   1                 asynchronous reset, active-low
//  radio_sig    in   CHANNELS          raw PWM inputs, asynchronous to tmr_1Mhz
//  radio_val    out  CHANNELS*WIDTH    channel c at [c*WIDTH +: WIDTH]
//  radio_valid  out  CHANNELS          1 = channel has received a valid pulse within TIMEOUT
//  radio_upd    out  CHANNELS          one-cycle strobe when radio_val for that channel is updated
//  radio_err    out  CHANNELS          one-cycle strobe when a pulse is rejected (too short or too long)
// BEHAVIOUR
//  Reset (rst=0, async): radio_val = DEFAULT on all channels; radio_valid, radio_upd, radio_err = 0.
//   All synchronisers are cleared, counters are 0, and the FSM is in IDLE. This applies mid-pulse as well.
//  Input path per channel: 2-FF synchroniser, then a 3rd flop for edge detect.
//   rise = s2 & ~s3; fall = ~s2 & s3.
//  Per-channel FSM:
//   IDLE: wait for rise -> HIGH, pulse_cnt<=1.
//    A channel whose line is high out of reset waits for a fall, then a rise.
//   HIGH: pulse_cnt++ (saturating at 2^12-1).
//    On fall with MIN_PULSE<=pulse_cnt<=MAX_PULSE: accept and go to IDLE.
//    On fall with pulse_cnt<MIN_PULSE: reject (radio_err strobe) and go to IDLE.
//    If pulse_cnt reaches MAX_PULSE+1 while still high: reject (radio_err strobe) and go to WAIT_LOW.
//   WAIT_LOW: ignore the line until fall, then go to IDLE (no second err strobe).
//  Accept: radio_val <= sat(pulse_cnt-OFFSET), clamped to 0 if negative and to 2^WIDTH-1 if above.
//   Also radio_upd=1 for one cycle, radio_valid<=1, and the timeout counter clears. All take effect on the
//   clock after the fall-detect cycle, i.e. 3 tmr_1Mhz edges after the first edge sampling the raw low level.
//   Measured width equals the raw high time in whole us, +/-1 tick.
//  Timeout: a per-channel counter (>=15 bits) increments every cycle and clears on accept; it saturates at TIMEOUT.
//   When it reaches TIMEOUT: radio_valid<=0 and radio_val<=DEFAULT on the same edge.
//   Rejected pulses do not clear it. An accept on the same cycle that timeout would fire wins.
//  radio_upd and radio_err for a channel never assert in the same cycle.
//  Channels are fully independent. Simultaneous edges on any subset of channels are handled in parallel.
//  radio_val is held stable between radio_upd strobes, except for the timeout fallback.
// TESTING
//  T1 reset: rst=0 with all sig toggling -> val=DEFAULT, valid=0, upd=0; release -> nothing for the first partial pulse.
//  T2 nominal: ch0 1500 us pulses at a 20 ms frame -> radio_val[9:0]=512, one upd per frame, valid=1 after first pulse.
//  T3 clamps: ch1 900 us -> val=0; ch1 2100 us -> val=1023; both accepted, upd=1, err=0.
//  T4 reject: ch2 500 us -> err strobe, val unchanged; ch2 3000 us -> one err at 2201 us, no upd, val unchanged.
//  T5 timeout: ch3 valid at 1200 us (val=212), then line held low -> valid=0 and val=DEFAULT exactly 25000 ticks after the accept.
//  T6 parallel + mid-reset: all 8 channels with distinct widths 1000..1700 step 100 -> val 12,112..712.
//   Assert rst during a pulse -> outputs reset immediately and no stale upd after release.

Source files
------------

// File: rtl/radio_bank.sv
// N-channel RC receiver PWM decoder: measures high-pulse width in 1 us ticks,
// offsets/saturates it, rejects out-of-range pulses and falls back on timeout.
module radio_bank #(
  parameter int CHANNELS  = 8,
  parameter int WIDTH     = 10,
  parameter int OFFSET    = 988,
  parameter int MIN_PULSE = 800,
  parameter int MAX_PULSE = 2200,
  parameter int TIMEOUT   = 25000,
  parameter logic [WIDTH-1:0] DEFAULT = '0
) (
  input  logic                      tmr_1Mhz,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       radio_sig,
  output logic [CHANNELS*WIDTH-1:0] radio_val,
  output logic [CHANNELS-1:0]       radio_valid,
  output logic [CHANNELS-1:0]       radio_upd,
  output logic [CHANNELS-1:0]       radio_err
);

  localparam int CNT_W = 12;
  localparam int TMO_W = ($clog2(TIMEOUT + 1) > 15) ? $clog2(TIMEOUT + 1) : 15;
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_PULSE);
  localparam logic [TMO_W-1:0] TMO_SAT  = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_FIRE = TMO_W'(TIMEOUT - 1);
  localparam logic [31:0]      OFF_C    = 32'(OFFSET);
  localparam logic [31:0]      VMAX_C   = 32'((1 << WIDTH) - 1);

  typedef enum logic [1:0] {IDLE, HIGH, WAIT_LOW} state_t;

  // Edges are ignored until the synchroniser chain holds three real samples,
  // so a line already high at reset release is not mistaken for a rise.
  logic [1:0] prime_q, prime_d;
  logic       primed;

  always_comb begin
    prime_d = (prime_q == 2'd3) ? prime_q : prime_q + 2'd1;
  end

  assign primed = (prime_q == 2'd3);

  always_ff @(posedge tmr_1Mhz or negedge rst) begin
    if (!rst) prime_q <= 2'd0;
    else      prime_q <= prime_d;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic             s1_q, s2_q, s3_q;
    logic             rise, fall;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic             valid_q, valid_d;
    logic             upd_q, upd_d;
    logic             err_q, err_d;
    logic             accept;
    logic [31:0]      cnt_ext, diff;
    logic [WIDTH-1:0] sat_val;

    assign rise = primed & s2_q & ~s3_q;
    assign fall = primed & ~s2_q & s3_q;

    always_ff @(posedge tmr_1Mhz or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE:     if (rise) state_d = HIGH;
        HIGH: begin
          if (fall)              state_d = IDLE;
          else if (cnt_q > MAX_C) state_d = WAIT_LOW;
        end
        WAIT_LOW: if (fall) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end

    always_comb begin
      cnt_ext = {{(32-CNT_W){1'b0}}, cnt_q};
      diff    = cnt_ext - OFF_C;
      if (cnt_ext < OFF_C)    sat_val = '0;
      else if (diff > VMAX_C) sat_val = VMAX_C[WIDTH-1:0];
      else                    sat_val = diff[WIDTH-1:0];
    end

    always_comb begin
      cnt_d   = cnt_q;
      val_d   = val_q;
      valid_d = valid_q;
      upd_d   = 1'b0;
      err_d   = 1'b0;
      accept  = 1'b0;
      tmo_d   = (tmo_q == TMO_SAT) ? tmo_q : tmo_q + TMO_W'(1);
      case (state_q)
        IDLE: if (rise) cnt_d = CNT_W'(1);
        HIGH: begin
          if (fall) begin
            if (cnt_q >= MIN_C && cnt_q <= MAX_C) accept = 1'b1;
            else                                  err_d  = 1'b1;
          end else if (cnt_q > MAX_C) begin
            err_d = 1'b1;
          end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
      // An accept on the timeout cycle takes priority over the fallback.
      if (accept) begin
        val_d   = sat_val;
        valid_d = 1'b1;
        upd_d   = 1'b1;
        tmo_d   = '0;
      end else if (tmo_q == TMO_FIRE) begin
        val_d   = DEFAULT;
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge tmr_1Mhz or negedge rst) begin
      if (!rst) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        s3_q    <= 1'b0;
        cnt_q   <= '0;
        tmo_q   <= '0;
        val_q   <= DEFAULT;
        valid_q <= 1'b0;
        upd_q   <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        s1_q    <= radio_sig[c];
        s2_q    <= s1_q;
        s3_q    <= s2_q;
        cnt_q   <= cnt_d;
        tmo_q   <= tmo_d;
        val_q   <= val_d;
        valid_q <= valid_d;
        upd_q   <= upd_d;
        err_q   <= err_d;
      end
    end

    assign radio_val[c*WIDTH +: WIDTH] = val_q;
    assign radio_valid[c]              = valid_q;
    assign radio_upd[c]                = upd_q;
    assign radio_err[c]                = err_q;
  end

endmodule

// File: tb/tb_radio_bank.sv
// Directed + randomized bench for radio_bank against a pulse-width reference model.
`timescale 1ns/100ps
module tb_radio_bank;
  localparam int CH = 8;
  localparam int W  = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CH-1:0] radio_sig = '0;
  logic [CH*W-1:0] radio_val;
  logic [CH-1:0] radio_valid, radio_upd, radio_err;

  int errors = 0;
  int checks = 0;

  radio_bank dut (
    .tmr_1Mhz   (clk),
    .rst        (rst),
    .radio_sig  (radio_sig),
    .radio_val  (radio_val),
    .radio_valid(radio_valid),
    .radio_upd  (radio_upd),
    .radio_err  (radio_err)
  );

  always #5 clk = ~clk;

  // event monitor: counts strobes and timestamps them in cycles
  int cyc = 0;
  int upd_cnt [CH];
  int err_cnt [CH];
  int upd_cyc [CH];
  int fall_cyc[CH];
  int both_cnt = 0;
  logic [CH-1:0] valid_prev = '0;

  initial begin
    for (int c = 0; c < CH; c++) begin
      upd_cnt[c] = 0; err_cnt[c] = 0; upd_cyc[c] = 0; fall_cyc[c] = 0;
    end
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int c = 0; c < CH; c++) begin
      if (radio_upd[c]) begin upd_cnt[c] = upd_cnt[c] + 1; upd_cyc[c] = cyc; end
      if (radio_err[c]) err_cnt[c] = err_cnt[c] + 1;
      if (radio_upd[c] && radio_err[c]) both_cnt = both_cnt + 1;
      if (valid_prev[c] && !radio_valid[c]) fall_cyc[c] = cyc;
    end
    valid_prev = radio_valid;
  end

  // reference model state
  int   exp_val[CH];
  logic exp_valid[CH];
  int   upd0[CH];
  int   err0[CH];
  int   pw[CH];
  logic [CH-1:0] pen;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int getval(input int c);
    logic [CH*W-1:0] v;
    v = radio_val;
    return int'(v[c*W +: W]);
  endfunction

  function automatic int model_val(input int w);
    if (w < 988) return 0;
    if (w - 988 > 1023) return 1023;
    return w - 988;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin exp_val[c] = 0; exp_valid[c] = 1'b0; end
  endtask

  task automatic snap();
    for (int c = 0; c < CH; c++) begin upd0[c] = upd_cnt[c]; err0[c] = err_cnt[c]; end
  endtask

  // drive all enabled channels high together, each low after pw[c] ticks
  task automatic run_pulses();
    int maxw;
    maxw = 0;
    for (int c = 0; c < CH; c++) if (pen[c] && pw[c] > maxw) maxw = pw[c];
    snap();
    radio_sig = radio_sig | pen;
    for (int t = 1; t <= maxw; t++) begin
      step(1);
      for (int c = 0; c < CH; c++) if (pen[c] && pw[c] == t) radio_sig[c] = 1'b0;
    end
    step(8);
  endtask

  task automatic check_round(input string tag);
    int eu, ee;
    for (int c = 0; c < CH; c++) begin
      eu = 0; ee = 0;
      if (pen[c]) begin
        if (pw[c] >= 800 && pw[c] <= 2200) begin
          eu = 1; exp_val[c] = model_val(pw[c]); exp_valid[c] = 1'b1;
        end else begin
          ee = 1;
        end
      end
      if (pen[c]) begin
        chk($sformatf("%s_upd_ch%0d", tag, c), upd_cnt[c] - upd0[c], eu);
        chk($sformatf("%s_err_ch%0d", tag, c), err_cnt[c] - err0[c], ee);
      end
      chk($sformatf("%s_val_ch%0d", tag, c), getval(c), exp_val[c]);
      chk($sformatf("%s_valid_ch%0d", tag, c), int'(radio_valid[c]), int'(exp_valid[c]));
    end
  endtask

  initial begin
    int t0, bad;
    model_reset();

    // T1: reset held while inputs toggle
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      radio_sig = CH'($urandom);
      step(1);
      if (radio_val !== '0 || radio_valid !== '0 || radio_upd !== '0 || radio_err !== '0) bad++;
    end
    chk("reset_outputs_quiet", bad, 0);
    chk("reset_val", int'(radio_val != '0), 0);
    radio_sig = '1;
    step(1);
    rst = 1'b1;
    snap();
    step(20);
    radio_sig = '0;
    step(10);
    bad = 0;
    for (int c = 0; c < CH; c++) bad += (upd_cnt[c] - upd0[c]) + (err_cnt[c] - err0[c]);
    chk("partial_pulse_ignored", bad, 0);
    chk("partial_valid", int'(radio_valid), 0);
    step(10);

    // T6: all channels in parallel, distinct widths
    pen = '1;
    for (int c = 0; c < CH; c++) pw[c] = 1000 + 100 * c;
    run_pulses();
    check_round("parallel");

    // mid-pulse reset
    radio_sig = '1;
    step(500);
    rst = 1'b0;
    #1;
    chk("midrst_val", int'(radio_val != '0), 0);
    chk("midrst_valid", int'(radio_valid), 0);
    chk("midrst_upd", int'(radio_upd), 0);
    model_reset();
    step(5);
    rst = 1'b1;
    snap();
    step(300);
    radio_sig = '0;
    step(20);
    bad = 0;
    for (int c = 0; c < CH; c++) bad += (upd_cnt[c] - upd0[c]) + (err_cnt[c] - err0[c]);
    chk("midrst_no_stale_upd", bad, 0);
    chk("midrst_val_after", int'(radio_val != '0), 0);

    // T3: clamps on ch1
    pen = 8'h02; pw[1] = 900;  run_pulses(); check_round("clamp_lo");
    pen = 8'h02; pw[1] = 2100; run_pulses(); check_round("clamp_hi");

    // T4: rejects on ch2
    pen = 8'h04; pw[2] = 500;  run_pulses(); check_round("short");
    pen = 8'h04; pw[2] = 3000; run_pulses(); check_round("long");

    // boundaries of the accept window and the clamp
    pen = '1;
    pw[0] = 799; pw[1] = 800; pw[2] = 2200; pw[3] = 2201;
    pw[4] = 988; pw[5] = 2011; pw[6] = 2012; pw[7] = 989;
    run_pulses();
    check_round("bound");

    // randomized rounds
    for (int r = 0; r < 4; r++) begin
      pen = CH'($urandom_range(1, 255));
      for (int c = 0; c < CH; c++) pw[c] = $urandom_range(600, 2400);
      run_pulses();
      check_round($sformatf("rand%0d", r));
    end

    // T2: ch0 1500 us at a 20 ms frame
    t0 = cyc;
    pen = 8'h01; pw[0] = 1500;
    run_pulses();
    chk("frame1_upd", upd_cnt[0] - upd0[0], 1);
    chk("frame1_val", getval(0), 512);
    chk("frame1_valid", int'(radio_valid[0]), 1);
    step(20000 - (cyc - t0));
    run_pulses();
    chk("frame2_upd", upd_cnt[0] - upd0[0], 1);
    chk("frame2_val", getval(0), 512);
    chk("frame2_valid", int'(radio_valid[0]), 1);

    // T5: ch3 timeout exactly 25000 ticks after accept
    pen = 8'h08; pw[3] = 1200;
    run_pulses();
    chk("tmo_accept_val", getval(3), 212);
    chk("tmo_accept_valid", int'(radio_valid[3]), 1);
    step(25010);
    chk("tmo_delay", fall_cyc[3] - upd_cyc[3], 25000);
    chk("tmo_valid", int'(radio_valid), 0);
    chk("tmo_val_default", int'(radio_val != '0), 0);
    chk("upd_err_exclusive", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
